uart_tx_port: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 35 +++
 rtl/uart_tx_port_fifo.sv | 56 +++++
 rtl/uart_tx_port.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_port.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants, status bit layout and FSM encoding
// for the store-path UART transmitter.
package uart_tx_pkg;

    localparam logic [7:0] TX_ADDR_DEF     = 8'hFE;
    localparam logic [7:0] STATUS_ADDR_DEF = 8'hFD;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic logic [7:0] pack_status(
        input logic ovf,
        input logic empty,
        input logic full,
        input logic busy
    );
        logic [7:0] s;
        s = 8'h00;
        s[ST_OVF]   = ovf;
        s[ST_EMPTY] = empty;
        s[ST_FULL]  = full;
        s[ST_BUSY]  = busy;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_port_fifo.sv
// Circular byte FIFO; a push while full is taken only
// when a pop frees a slot in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter snooping the CPU
// store path, with a small byte FIFO and polled status.
module uart_tx_port
    import uart_tx_pkg::*;
#(
    parameter int         CLK_HZ      = 50000000,
    parameter int         BAUD        = 115200,
    parameter int         DIV         = CLK_HZ / BAUD,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] TX_ADDR     = TX_ADDR_DEF,
    parameter logic [7:0] STATUS_ADDR = STATUS_ADDR_DEF
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] Address,
    input  logic [7:0] RegData,
    input  logic       We,
    output logic       Tx,
    output logic [7:0] Status,
    output logic       Busy
);

    localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic       we_s1, we_s2;
    logic [7:0] addr_s1, addr_s2;
    logic [7:0] data_s1, data_s2;

    logic req_tx, req_tx_q, wr_tx;
    logic req_st, req_st_q, wr_st;

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [7:0]    fifo_dout;
    logic          accept;
    logic          overflow;

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          tx_q, tx_d;
    logic          pop, load, shift;
    logic          baud_last;
    logic          ovf_q;
    logic          busy;
    logic [7:0]    status_q;

    // Inputs come from a key-stepped CPU; resample before use
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            we_s1   <= 1'b0;
            we_s2   <= 1'b0;
            addr_s1 <= '0;
            addr_s2 <= '0;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            we_s1   <= We;
            we_s2   <= we_s1;
            addr_s1 <= Address;
            addr_s2 <= addr_s1;
            data_s1 <= RegData;
            data_s2 <= data_s1;
        end
    end

    assign req_tx = we_s2 & (addr_s2 == TX_ADDR);
    assign req_st = we_s2 & (addr_s2 == STATUS_ADDR);
    assign wr_tx  = req_tx & ~req_tx_q;
    assign wr_st  = req_st & ~req_st_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            req_tx_q <= 1'b0;
            req_st_q <= 1'b0;
        end else begin
            req_tx_q <= req_tx;
            req_st_q <= req_st;
        end
    end

    assign accept   = wr_tx & ((fifo_cnt < CW'(FIFO_DEPTH)) | pop);
    assign overflow = wr_tx & ~accept;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (accept),
        .din   (data_s2),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign baud_last = (baud_q == BW'(DIV - 1));

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift = 1'b1;
                        tx_d  = shreg_q[1];
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    // Chain straight into the next frame when queued
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            if (state_q == IDLE || baud_last)
                baud_q <= '0;
            else
                baud_q <= baud_q + BW'(1);
            if (state_q == START)
                bit_q <= '0;
            else if (state_q == DATA && baud_last)
                bit_q <= bit_q + 3'd1;
            if (load)
                shreg_q <= fifo_dout;
            else if (shift)
                shreg_q <= {1'b0, shreg_q[7:1]};
        end
    end

    assign busy = (state_q != IDLE) | ~fifo_empty;

    // A new overflow in the clearing cycle keeps ovf set
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ovf_q    <= 1'b0;
            status_q <= 8'h04;
        end else begin
            if (overflow)
                ovf_q <= 1'b1;
            else if (wr_st)
                ovf_q <= 1'b0;
            status_q <= pack_status(ovf_q, fifo_empty,
                                    fifo_full, busy);
        end
    end

    assign Tx     = tx_q;
    assign Status = status_q;
    assign Busy   = busy;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with DIV=10: checks line
// waveform, status byte and busy against hand-built frames.
module tb_uart_tx_port;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [7:0] Address = 8'h00;
    logic [7:0] RegData = 8'h00;
    logic       We = 1'b0;
    logic       Tx;
    logic [7:0] Status;
    logic       Busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         at;
        logic [7:0] addr;
        logic [7:0] data;
        int         hold;
    } ev_t;

    ev_t        sched[$];
    logic       tx_log [0:1023];
    logic [7:0] st_log [0:1023];
    logic       bz_log [0:1023];
    logic [7:0] fb [8];

    uart_tx_port #(
        .CLK_HZ      (1000),
        .BAUD        (100),
        .FIFO_DEPTH  (4),
        .TX_ADDR     (8'hFE),
        .STATUS_ADDR (8'hFD)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Address (Address),
        .RegData (RegData),
        .We      (We),
        .Tx      (Tx),
        .Status  (Status),
        .Busy    (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        We = 1'b0;
        Address = 8'h00;
        RegData = 8'h00;
        sched.delete();
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic add_store(input int at, input logic [7:0] a,
                             input logic [7:0] d, input int hold);
        ev_t e;
        e.at = at;
        e.addr = a;
        e.data = d;
        e.hold = hold;
        sched.push_back(e);
    endtask

    // Cycle i drives inputs, log[i+1] holds outputs after the next edge
    task automatic run(input int n);
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        tx_log[0] = Tx;
        st_log[0] = Status;
        bz_log[0] = Busy;
        for (int i = 0; i < n; i++) begin
            w = 1'b0;
            a = 8'h00;
            d = 8'h00;
            foreach (sched[k]) begin
                if (i >= sched[k].at && i < sched[k].at + sched[k].hold) begin
                    w = 1'b1;
                    a = sched[k].addr;
                    d = sched[k].data;
                end
            end
            We = w;
            Address = a;
            RegData = d;
            @(posedge Clk);
            #1;
            tx_log[i+1] = Tx;
            st_log[i+1] = Status;
            bz_log[i+1] = Busy;
        end
        We = 1'b0;
        Address = 8'h00;
        RegData = 8'h00;
    endtask

    function automatic logic exp_tx(input int c, input int first,
                                    input int nfr);
        int off, f, idx;
        logic [7:0] b;
        if (c < first) return 1'b1;
        off = c - first;
        f = off / 100;
        if (f >= nfr) return 1'b1;
        idx = (off % 100) / 10;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        b = fb[f];
        return b[idx-1];
    endfunction

    task automatic check_line(input string tag, input int from,
                              input int to, input int first,
                              input int nfr);
        for (int c = from; c <= to; c++)
            check($sformatf("%s_tx@%0d", tag, c),
                  32'(tx_log[c]), 32'(exp_tx(c, first, nfr)));
    endtask

    initial begin
        do_reset();
        check("rst_tx", 32'(Tx), 32'd1);
        check("rst_status", 32'(Status), 32'h04);
        check("rst_busy", 32'(Busy), 32'd0);

        // single byte, We held 50 cycles
        fb[0] = 8'hA5;
        add_store(0, 8'hFE, 8'hA5, 50);
        run(250);
        check("t1_pre_fall", 32'(tx_log[3]), 32'd1);
        check("t1_fall", 32'(tx_log[4]), 32'd0);
        check_line("t1", 1, 250, 4, 1);
        check("t1_busy_end", 32'(bz_log[103]), 32'd1);
        check("t1_idle", 32'(bz_log[104]), 32'd0);
        check("t1_status", 32'(st_log[250]), 32'h04);

        // three back-to-back stores
        do_reset();
        fb[0] = 8'h01;
        fb[1] = 8'h02;
        fb[2] = 8'h03;
        add_store(0, 8'hFE, 8'h01, 2);
        add_store(4, 8'hFE, 8'h02, 2);
        add_store(8, 8'hFE, 8'h03, 2);
        run(320);
        check_line("t2", 1, 320, 4, 3);
        check("t2_gap1", 32'(tx_log[104]), 32'd0);
        check("t2_gap2", 32'(tx_log[204]), 32'd0);
        check("t2_busy", 32'(bz_log[303]), 32'd1);
        check("t2_idle", 32'(bz_log[304]), 32'd0);

        // overflow and clear
        do_reset();
        for (int k = 0; k < 6; k++)
            add_store(8 * k, 8'hFE, 8'(8'h41 + k), 4);
        add_store(48, 8'hFD, 8'h99, 4);
        run(60);
        check("t3_full", 32'(st_log[40]), 32'h03);
        check("t3_ovf", 32'(st_log[46]), 32'h0B);
        check("t3_clear", 32'(st_log[56]), 32'h03);
        check("t3_first_bit", 32'(tx_log[15]), 32'd1);

        // address filter
        do_reset();
        add_store(0, 8'hFF, 8'h55, 4);
        add_store(10, 8'h10, 8'h66, 4);
        run(60);
        begin
            int lows;
            lows = 0;
            for (int c = 1; c <= 60; c++)
                if (tx_log[c] !== 1'b1) lows++;
            check("t4_tx_low_cycles", 32'(lows), 32'd0);
        end
        check("t4_status_mid", 32'(st_log[20]), 32'h04);
        check("t4_status_end", 32'(st_log[60]), 32'h04);
        check("t4_busy", 32'(bz_log[60]), 32'd0);

        // reset during bit 3 with two bytes queued
        do_reset();
        fb[0] = 8'hF0;
        add_store(0, 8'hFE, 8'hF0, 2);
        add_store(4, 8'hFE, 8'h11, 2);
        add_store(8, 8'hFE, 8'h22, 2);
        run(48);
        check("t5_bit3", 32'(tx_log[48]), 32'd0);
        check("t5_queued", 32'(st_log[48]), 32'h01);
        Rst = 1'b1;
        #1;
        check("t5_async_tx", 32'(Tx), 32'd1);
        check("t5_async_status", 32'(Status), 32'h04);
        #20;
        Rst = 1'b0;
        sched.delete();
        run(150);
        check("t5_status", 32'(st_log[1]), 32'h04);
        check("t5_busy", 32'(bz_log[1]), 32'd0);
        begin
            int lows;
            lows = 0;
            for (int c = 1; c <= 150; c++)
                if (tx_log[c] !== 1'b1) lows++;
            check("t5_silent_cycles", 32'(lows), 32'd0);
        end
        fb[0] = 8'h3C;
        add_store(0, 8'hFE, 8'h3C, 3);
        run(120);
        check_line("t5_new", 1, 120, 4, 1);

        // full FIFO, store accepted on the STOP->START pop cycle
        do_reset();
        for (int k = 0; k < 6; k++)
            fb[k] = 8'(8'h11 * (k + 1));
        for (int k = 0; k < 5; k++)
            add_store(8 * k, 8'hFE, fb[k], 4);
        add_store(101, 8'hFE, fb[5], 4);
        run(700);
        check("t6_full", 32'(st_log[103]), 32'h03);
        check("t6_no_ovf", 32'(st_log[110]), 32'h03);
        check("t6_ovf_late", 32'(st_log[300][3]), 32'd0);
        check_line("t6", 1, 700, 4, 6);
        check("t6_busy", 32'(bz_log[603]), 32'd1);
        check("t6_idle", 32'(bz_log[604]), 32'd0);
        check("t6_status_end", 32'(st_log[700]), 32'h04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
